key_onehot_capture: RTL and testbench

//  Upstream stage of the 8-3 encoder. Synchronises and debounces 8 raw active-high key/switch

---
 rtl/key_onehot_capture_pkg.sv | 18 +
 rtl/key_onehot_capture_sync2ff.sv | 31 +++
 rtl/key_onehot_capture.sv | 125 ++++++++++++
 tb/tb_key_onehot_capture.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_onehot_capture_pkg.sv
// -----------------------------------------------------------------------------
// key_onehot_capture_pkg
// Shared definitions for the key capture front end of the 8-3 encoder:
//   KEY_W       - number of key lines (D7..D0)
//   keyState_t  - capture FSM states (IDLE, DEBOUNCE, HOLD, RELEASE)
// -----------------------------------------------------------------------------
package key_onehot_capture_pkg;

    localparam int KEY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } keyState_t;

endpackage

// File: rtl/key_onehot_capture_sync2ff.sv
// -----------------------------------------------------------------------------
// key_onehot_capture_sync2ff
// Two-flop synchroniser, one independent chain per bit.
// Ports:
//   clk    in  1      destination clock
//   rst    in  1      asynchronous active-high reset (clears both stages)
//   async  in  WIDTH  lines asynchronous to clk
//   sync   out WIDTH  synchronised copy, two clk cycles behind
// -----------------------------------------------------------------------------
module key_onehot_capture_sync2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async,
    output logic [WIDTH-1:0] sync
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= async;
            sync <= meta;
        end
    end

endmodule

// File: rtl/key_onehot_capture.sv
// -----------------------------------------------------------------------------
// key_onehot_capture
// Synchronises and debounces 8 raw active-high key lines and accepts exactly
// one single-key press per press/release cycle. oData feeds the encoder's
// iData[7:0] directly.
// Parameters:
//   DEBOUNCE_CYCLES  cycles a key pattern must stay unchanged to be accepted (>=1)
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   iKey    in   8  raw key lines D7..D0, asynchronous to clk
//   oData   out  8  one-hot code of the last accepted key, 8'h00 until first accept
//   oValid  out  1  one-cycle pulse in the cycle oData updates
//   oBusy   out  1  high whenever the FSM is not idle
//   oErr    out  1  multi-key flag, present only with KEY_MULTI_ERR_EN defined
// Build option:
//   KEY_MULTI_ERR_EN  adds oErr; without it multi-key presses are dropped silently.
// -----------------------------------------------------------------------------
module key_onehot_capture
    import key_onehot_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] iKey,
    output logic [KEY_W-1:0] oData,
    output logic             oValid,
    output logic             oBusy
`ifdef KEY_MULTI_ERR_EN
    ,
    output logic             oErr
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] ksync;
    logic [KEY_W-1:0] snapshot;
    logic [CNT_W-1:0] cnt;
    keyState_t        state;
    logic             snapOneHot;

    key_onehot_capture_sync2ff #(
        .WIDTH (KEY_W)
    ) uSync (
        .clk   (clk),
        .rst   (rst),
        .async (iKey),
        .sync  (ksync)
    );

    assign snapOneHot = (snapshot != '0) && ((snapshot & (snapshot - KEY_W'(1))) == '0);
    assign oBusy      = (state != ST_IDLE);

    // oData/oValid are loaded on the DEBOUNCE->HOLD edge so the strobe is
    // high exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            snapshot <= '0;
            cnt      <= '0;
            oData    <= '0;
            oValid   <= 1'b0;
`ifdef KEY_MULTI_ERR_EN
            oErr     <= 1'b0;
`endif
        end else begin
            oValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ksync != '0) begin
                        snapshot <= ksync;
                        cnt      <= '0;
                        state    <= ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (ksync == '0) begin
                        state <= ST_IDLE;
                    end else if (ksync != snapshot) begin
                        // Pattern moved: restart the stability window on the new one.
                        snapshot <= ksync;
                        cnt      <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state <= ST_HOLD;
                        if (snapOneHot) begin
                            oData  <= snapshot;
                            oValid <= 1'b1;
`ifdef KEY_MULTI_ERR_EN
                            oErr   <= 1'b0;
                        end else begin
                            oErr   <= 1'b1;
`endif
                        end
                    end
                end

                ST_HOLD: begin
                    cnt   <= '0;
                    state <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    // Any key still down restarts the release window; a key
                    // change while held never produces a second accept.
                    if (ksync != '0) begin
                        cnt <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_onehot_capture.sv
// -----------------------------------------------------------------------------
// tb_key_onehot_capture
// Self-checking bench for key_onehot_capture (DEBOUNCE_CYCLES = 4).
// Reference model: a key pattern is accepted once its synchronised value has
// been seen unchanged and nonzero on D+1 consecutive clock edges while armed;
// after an accept (one edge spent in HOLD) the capture re-arms only after D
// consecutive all-released samples.
// -----------------------------------------------------------------------------
module tb_key_onehot_capture;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [7:0] iKey;
    logic [7:0] oData;
    logic       oValid;
    logic       oBusy;
`ifdef KEY_MULTI_ERR_EN
    logic       oErr;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] mS1, mS2, mRunPat, mData;
    logic       mArmed, mHoldEdge, mValid, mBusy, mErr;
    int         mZeroRun, mRun;

    key_onehot_capture #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iKey   (iKey),
        .oData  (oData),
        .oValid (oValid),
        .oBusy  (oBusy)
`ifdef KEY_MULTI_ERR_EN
        ,
        .oErr   (oErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mS1 = '0; mS2 = '0; mRunPat = '0; mData = '0;
        mArmed = 1'b1; mHoldEdge = 1'b0; mValid = 1'b0; mBusy = 1'b0; mErr = 1'b0;
        mZeroRun = 0; mRun = 0;
    endtask

    // Drive one key value for one clock and advance the reference model.
    task automatic step(input logic [7:0] key);
        logic [7:0] ks;
        @(negedge clk);
        iKey = key;
        @(posedge clk);
        ks  = mS2;
        mS2 = mS1;
        mS1 = key;
        mValid = 1'b0;
        if (mHoldEdge) begin
            mHoldEdge = 1'b0;
            mZeroRun  = 0;
        end else if (!mArmed) begin
            if (ks == 8'h00) mZeroRun++;
            else             mZeroRun = 0;
            if (mZeroRun == D) begin
                mArmed = 1'b1;
                mRun   = 0;
            end
        end else begin
            if (ks == 8'h00) mRun = 0;
            else if (mRun > 0 && ks == mRunPat) mRun++;
            else begin
                mRunPat = ks;
                mRun    = 1;
            end
            if (mRun == D + 1) begin
                if ($countones(ks) == 1) begin
                    mData  = ks;
                    mValid = 1'b1;
                    mErr   = 1'b0;
                end else begin
                    mErr = 1'b1;
                end
                mArmed    = 1'b0;
                mHoldEdge = 1'b1;
            end
        end
        mBusy = !mArmed || (ks != 8'h00);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iKey = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (oData !== 8'h00 || oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%h valid=%b busy=%b, want 00/0/0", oData, oValid, oBusy);
        end
        @(negedge clk);
        rst = 1'b0;
        // press a key, then reset while debouncing
        for (int i = 0; i < 5; i++) step(8'h10);
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: busy=%b, want 1", oBusy);
        end
        @(negedge clk);
        rst = 1'b1;
        iKey = 8'h00;
        modelReset();
        #1;
        checks++;
        if (oBusy !== 1'b0 || oValid !== 1'b0 || oData !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_debounce: data=%h valid=%b busy=%b, want 00/0/0", oData, oValid, oBusy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(8'h00);
            checks++;
            if (oValid !== 1'b0 || oData !== 8'h00 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL reset_after: cyc %0d data=%h valid=%b busy=%b, want 00/0/0", i, oData, oValid, oBusy);
            end
        end
    endtask

    task automatic test_single_key();
        int nValid = 0;
        int firstAt = -1;
        int enc = -1;
        for (int i = 1; i <= 30; i++) begin
            step(i <= 20 ? 8'h20 : 8'h00);
            checks++;
            if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                errors++;
                $display("FAIL single_model: cyc %0d valid %b/%b data %h/%h busy %b/%b (got/want)",
                         i, oValid, mValid, oData, mData, oBusy, mBusy);
            end
            if (oValid === 1'b1) begin
                nValid++;
                if (firstAt < 0) begin
                    firstAt = i;
                    for (int b = 0; b < 8; b++) if (oData[b]) enc = b;
                    checks++;
                    if (oData !== 8'h20 || enc != 5) begin
                        errors++;
                        $display("FAIL single_data: data=%h enc=%0d, want 20 enc=5", oData, enc);
                    end
                end
            end
        end
        checks++;
        if (nValid != 1 || firstAt != D + 3) begin
            errors++;
            $display("FAIL single_count: pulses=%0d at edge %0d, want 1 at edge %0d", nValid, firstAt, D + 3);
        end
    endtask

    task automatic test_glitch();
        int nValid = 0;
        for (int i = 0; i < 12; i++) begin
            step(i < 2 ? 8'h04 : 8'h00);
            checks++;
            if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                errors++;
                $display("FAIL glitch_model: cyc %0d valid %b/%b data %h/%h busy %b/%b (got/want)",
                         i, oValid, mValid, oData, mData, oBusy, mBusy);
            end
            if (oValid === 1'b1) nValid++;
        end
        checks++;
        if (nValid != 0 || oData !== 8'h20 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_result: pulses=%0d data=%h busy=%b, want 0/20/0", nValid, oData, oBusy);
        end
    endtask

    task automatic test_bounce();
        int nValid = 0;
        logic [7:0] k;
        for (int i = 0; i < 32; i++) begin
            if (i < 6)       k = (i % 2 == 0) ? 8'h08 : 8'h00;
            else if (i < 22) k = 8'h08;
            else             k = 8'h00;
            step(k);
            checks++;
            if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                errors++;
                $display("FAIL bounce_model: cyc %0d valid %b/%b data %h/%h busy %b/%b (got/want)",
                         i, oValid, mValid, oData, mData, oBusy, mBusy);
            end
            if (oValid === 1'b1) nValid++;
        end
        checks++;
        if (nValid != 1 || oData !== 8'h08) begin
            errors++;
            $display("FAIL bounce_result: pulses=%0d data=%h, want 1/08", nValid, oData);
        end
    endtask

    task automatic test_multi_key();
        int nValid = 0;
        for (int i = 0; i < 25; i++) begin
            step(i < 15 ? 8'h81 : 8'h00);
            checks++;
            if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                errors++;
                $display("FAIL multi_model: cyc %0d valid %b/%b data %h/%h busy %b/%b (got/want)",
                         i, oValid, mValid, oData, mData, oBusy, mBusy);
            end
            if (oValid === 1'b1) nValid++;
        end
        checks++;
        if (nValid != 0 || oData !== 8'h08) begin
            errors++;
            $display("FAIL multi_result: pulses=%0d data=%h, want 0/08", nValid, oData);
        end
`ifdef KEY_MULTI_ERR_EN
        checks++;
        if (oErr !== 1'b1) begin
            errors++;
            $display("FAIL multi_err_set: oErr=%b, want 1", oErr);
        end
`endif
        for (int i = 0; i < 25; i++) begin
            step(i < 15 ? 8'h02 : 8'h00);
            checks++;
            if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                errors++;
                $display("FAIL multi_next_model: cyc %0d valid %b/%b data %h/%h busy %b/%b (got/want)",
                         i, oValid, mValid, oData, mData, oBusy, mBusy);
            end
        end
        checks++;
        if (oData !== 8'h02) begin
            errors++;
            $display("FAIL multi_next_data: data=%h, want 02", oData);
        end
`ifdef KEY_MULTI_ERR_EN
        checks++;
        if (oErr !== 1'b0) begin
            errors++;
            $display("FAIL multi_err_clear: oErr=%b, want 0", oErr);
        end
`endif
    endtask

    task automatic test_switch_held();
        int nValid = 0;
        logic [7:0] k;
        for (int i = 0; i < 55; i++) begin
            if (i < 15)      k = 8'h01;
            else if (i < 30) k = 8'h40;
            else if (i < 40) k = 8'h00;
            else             k = 8'h40;
            step(k);
            checks++;
            if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                errors++;
                $display("FAIL switch_model: cyc %0d valid %b/%b data %h/%h busy %b/%b (got/want)",
                         i, oValid, mValid, oData, mData, oBusy, mBusy);
            end
            if (oValid === 1'b1) nValid++;
            if (i == 39) begin
                checks++;
                if (nValid != 1 || oData !== 8'h01) begin
                    errors++;
                    $display("FAIL switch_no_second: pulses=%0d data=%h, want 1/01", nValid, oData);
                end
            end
        end
        checks++;
        if (nValid != 2 || oData !== 8'h40) begin
            errors++;
            $display("FAIL switch_repress: pulses=%0d data=%h, want 2/40", nValid, oData);
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        int dur, sel, a, b;
        int cyc = 0;
        while (cyc < 600) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) k = 8'h00;
            else if (sel == 3) begin
                a = $urandom_range(0, 7);
                b = (a + $urandom_range(1, 7)) % 8;
                k = 8'(1 << a) | 8'(1 << b);
            end else k = 8'(1 << $urandom_range(0, 7));
            dur = $urandom_range(1, 12);
            for (int i = 0; i < dur; i++) begin
                step(k);
                cyc++;
                checks++;
                if (oValid !== mValid || oData !== mData || oBusy !== mBusy) begin
                    errors++;
                    $display("FAIL random_model: cyc %0d key %h valid %b/%b data %h/%h busy %b/%b (got/want)",
                             cyc, k, oValid, mValid, oData, mData, oBusy, mBusy);
                end
`ifdef KEY_MULTI_ERR_EN
                checks++;
                if (oErr !== mErr) begin
                    errors++;
                    $display("FAIL random_err: cyc %0d oErr=%b, want %b", cyc, oErr, mErr);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_bounce();
        test_multi_key();
        test_switch_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
